// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-cathode
// 7-segment digits sharing one BCD decoder.
// A packed BCD word is accepted through a valid/ready handshake into a pending
// buffer. It is committed to the display register only at a frame boundary, or
// at any time while the display is dark, so a frame never mixes two values.
// Each digit gets a slot of SLOT_CYCLES cycles. The first GUARD_CYCLES of every
// slot are blanked so that segment ghosting is avoided when the anode switches.
// Optional feature: define SEG_SCAN_LZ_BLANK_EN to enable leading-zero blanking.

module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              bcd,
    output logic                    cs,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int DIG_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]     GUARD_END = SLOT_W'(GUARD_CYCLES);
    localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    typedef enum logic [0:0] {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   pending_q, pending_d;
    logic                pend_flag_q, pend_flag_d;
    logic [DATA_W-1:0]   disp_q, disp_d;
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]    dig_idx_q, dig_idx_d;
    logic                load_ready_q, load_ready_d;
    logic [3:0]          bcd_q, bcd_d;
    logic                cs_q, cs_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                scan_on;
    logic                slot_last;
    logic [3:0]          cur_digit;
    logic [NUM_DIGITS-1:0] lz_mask;

    // Handshake and commit: accept into pending, move to disp at frame end or while dark.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        disp_d      = disp_q;
        if (pend_flag_q && (frame_done_q || state_q == ST_OFF)) begin
            disp_d      = pending_q;
            pend_flag_d = 1'b0;
        end else if (load_valid && load_ready_q) begin
            pending_d   = load_data;
            pend_flag_d = 1'b1;
        end
        load_ready_d = ~pend_flag_d;
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic seen_nz;

    // Leading-zero mask: a digit is dark when it and every digit above it are zero.
    always_comb begin
        seen_nz = 1'b0;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen_nz    = seen_nz | (disp_d[4*i +: 4] != 4'd0);
            lz_mask[i] = ~seen_nz;
        end
    end
`else
    // Leading zeros are shown: no digit is masked.
    always_comb begin
        lz_mask = '0;
    end
`endif

    // Slot/digit sequencing and next values of the registered display outputs.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        dig_idx_d  = dig_idx_q;
        slot_last  = (slot_cnt_q == SLOT_LAST);
        scan_on    = (state_q == ST_SCAN) && enable;

        case (state_q)
            ST_OFF: begin
                slot_cnt_d = '0;
                dig_idx_d  = '0;
                if (enable) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d    = ST_OFF;
                    slot_cnt_d = '0;
                    dig_idx_d  = '0;
                end else if (slot_last) begin
                    slot_cnt_d = '0;
                    dig_idx_d  = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // disp_d is used so a value committed at frame end is shown from digit 0's first cycle.
        cur_digit    = disp_d[4*dig_idx_q +: 4];
        an_d         = scan_on ? (AN_ONE << dig_idx_q) : '0;
        bcd_d        = scan_on ? cur_digit : 4'd0;
        cs_d         = scan_on && (slot_cnt_q >= GUARD_END) && (cur_digit <= 4'd9)
                       && !lz_mask[dig_idx_q];
        frame_done_d = scan_on && slot_last && (dig_idx_q == DIG_LAST);
    end

    // State and registered outputs; async reset darkens the display and drops any pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            pending_q    <= '0;
            pend_flag_q  <= 1'b0;
            disp_q       <= '0;
            slot_cnt_q   <= '0;
            dig_idx_q    <= '0;
            load_ready_q <= 1'b1;
            bcd_q        <= 4'd0;
            cs_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            disp_q       <= disp_d;
            slot_cnt_q   <= slot_cnt_d;
            dig_idx_q    <= dig_idx_d;
            load_ready_q <= load_ready_d;
            bcd_q        <= bcd_d;
            cs_q         <= cs_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign bcd        = bcd_q;
    assign cs         = cs_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
// The stimulus side runs a frame-position reference model at each rising edge and
// queues the expected outputs. A monitor pops one record at every falling edge
// and compares it with the DUT outputs.
// Build with SEG_SCAN_LZ_BLANK_EN defined to check leading-zero blanking.

module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 2;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       cs;
        logic       fd;
        logic       ready;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        lv;
    logic [15:0] ld;
    logic        load_ready;
    logic [3:0]  bcd;
    logic        cs;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state.
    bit          m_on;     // scanning
    int          m_pos;    // position within the frame, 0 .. N*S-1
    logic [15:0] m_disp;
    logic [15:0] m_pval;
    bit          m_pend;
    bit          m_fd;     // frame_done shown in the previous cycle

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SLOT_CYCLES  (S),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en),
        .load_valid (lv),
        .load_data  (ld),
        .load_ready (load_ready),
        .bcd        (bcd),
        .cs         (cs),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // One clock edge: compute the expected outputs for this edge and queue them.
    task automatic step();
        exp_t r;
        int   dig;
        int   slot;
        logic [3:0] v;
        bit   commit;
        bit   scan_on;
        bit   blank;
        bit   xfer;
        @(posedge clk);
        xfer = 1'b0;
        if (!rst_n) begin
            m_on = 0; m_pos = 0; m_disp = '0; m_pval = '0; m_pend = 0; m_fd = 0;
            r.an = '0; r.bcd = '0; r.cs = 1'b0; r.fd = 1'b0; r.ready = 1'b1;
        end else begin
            commit = m_pend && (m_fd || !m_on);
            if (commit) begin
                m_disp = m_pval;
                m_pend = 0;
            end else if (lv && !m_pend) begin
                m_pval = ld;
                m_pend = 1;
                xfer   = 1'b1;
            end
            scan_on = m_on && en;
            dig     = m_pos / S;
            slot    = m_pos % S;
            v       = m_disp[4*dig +: 4];
`ifdef SEG_SCAN_LZ_BLANK_EN
            blank   = (dig > 0) && ((m_disp >> (4*dig)) == 16'h0);
`else
            blank   = 1'b0;
`endif
            r.an    = scan_on ? (4'b0001 << dig) : 4'b0000;
            r.bcd   = scan_on ? v : 4'd0;
            r.cs    = scan_on && (slot >= G) && (v <= 4'd9) && !blank;
            r.fd    = scan_on && (m_pos == N*S - 1);
            r.ready = !m_pend;
            m_fd    = r.fd;
            if (!m_on) begin
                m_pos = 0;
                m_on  = en;
            end else if (!en) begin
                m_on  = 0;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % (N*S);
            end
        end
        exp_q.push_back(r);
        #1;
        if (xfer) lv = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Producer: offer a value and hold it until it is taken.
    task automatic send(input logic [15:0] val);
        int n;
        lv = 1'b1;
        ld = val;
        n  = 0;
        while (lv && n < 200) begin
            step();
            n++;
        end
        check("send_timeout", {31'd0, lv}, 32'd0);
        lv = 1'b0;
    endtask

    // Reset pulse applied between edges, with an immediate look at the outputs.
    task automatic reset_pulse();
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_an", {28'd0, an}, 32'd0);
        check("rst_cs", {31'd0, cs}, 32'd0);
        check("rst_bcd", {28'd0, bcd}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 9) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
        return w;
    endfunction

    // Monitor: compare one queued expectation at every falling edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("an", {28'd0, an}, {28'd0, r.an});
                check("bcd", {28'd0, bcd}, {28'd0, r.bcd});
                check("cs", {31'd0, cs}, {31'd0, r.cs});
                check("frame_done", {31'd0, frame_done}, {31'd0, r.fd});
                check("load_ready", {31'd0, load_ready}, {31'd0, r.ready});
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        rst_n = 1'b0;
        en    = 1'b0;
        lv    = 1'b0;
        ld    = '0;
        m_on = 0; m_pos = 0; m_disp = '0; m_pval = '0; m_pend = 0; m_fd = 0;
        run(3);
        rst_n = 1'b1;

        // Commit 1234 while dark, then scan two frames.
        send(16'h1234);
        run(2);
        en = 1'b1;
        run(2*N*S);

        // Mid-frame load: current frame keeps 1234, the next shows 5678.
        run(11);
        send(16'h5678);
        run(2*N*S + 4);

        // Invalid code in digit 2 darkens only that slot.
        send(16'h1A34);
        run(2*N*S + 4);

        // Drop enable at slot 5 of digit 1, then re-enable.
        n = 0;
        while (!(m_on && m_pos == S + 5) && n < 100) begin
            step();
            n++;
        end
        check("reach_drop_point", n < 100 ? 32'd1 : 32'd0, 32'd1);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(N*S + 5);

        // Leading-zero patterns.
        send(16'h0040);
        run(2*N*S + 4);
        send(16'h0000);
        run(2*N*S + 4);

        // Randomized traffic: enable toggling and producer offers of random words.
        for (int c = 0; c < 1500; c++) begin
            if (en && $urandom_range(0, 99) < 2)       en = 1'b0;
            else if (!en && $urandom_range(0, 9) < 3)  en = 1'b1;
            if (!lv && $urandom_range(0, 99) < 6) begin
                lv = 1'b1;
                ld = rand_word();
            end
            step();
        end
        lv = 1'b0;

        // Reset mid-slot with a pending value: it must be discarded.
        en = 1'b1;
        send(16'h9876);
        run(N*S + 3);
        lv = 1'b1;
        ld = 16'h4321;
        step();
        lv = 1'b0;
        run(2);
        reset_pulse();
        run(2*N*S + 4);

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
